// File: rtl/mem_streams_pkg.sv
// Shared types for the ping-pong block memory.
// Bank occupancy enum and bank count.
package mem_streams_pkg;

  localparam int NUM_BANKS = 2;

  typedef enum logic {
    FREE = 1'b0,
    FULL = 1'b1
  } bank_state_e;

endpackage

// File: rtl/Simple_Dual_Port_BRAM_XPM_intel.sv
// Simple dual-port RAM: one write port, one read port,
// fixed read latency, contents survive reset.
module Simple_Dual_Port_BRAM_XPM_intel #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] pipe_q [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (wea) mem[addra] <= dina;
    if (enb) pipe_q[0] <= mem[addrb];
    for (int i = 1; i < READ_LATENCY; i++)
      pipe_q[i] <= pipe_q[i-1];
  end

  assign doutb = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/pp_bank_ctrl.sv
// Ping-pong bank bookkeeping: bank states, write/read
// pointers, ready flags and dropped-write pulse.
module pp_bank_ctrl
  import mem_streams_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_wr_wen,
  input  logic i_wr_last,
  input  logic i_rd_ren,
  input  logic i_rd_last,
  output logic o_wr_ready,
  output logic o_rd_ready,
  output logic o_wr_acc,
  output logic o_rd_acc,
  output logic o_wr_bank,
  output logic o_rd_bank,
  output logic o_overflow
);

  bank_state_e state_q [NUM_BANKS];
  bank_state_e state_d [NUM_BANKS];
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic        ovf_q, ovf_d;

  assign o_wr_ready = (state_q[wr_bank_q] == FREE);
  assign o_rd_ready = (state_q[rd_bank_q] == FULL);
  assign o_wr_acc   = i_wr_wen & o_wr_ready;
  assign o_rd_acc   = i_rd_ren & o_rd_ready;
  assign o_wr_bank  = wr_bank_q;
  assign o_rd_bank  = rd_bank_q;
  assign o_overflow = ovf_q;

  // Commit and release never target the same bank:
  // one needs FREE, the other FULL.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    ovf_d     = i_wr_wen & ~o_wr_ready;
    if (o_wr_acc && i_wr_last) begin
      state_d[wr_bank_q] = FULL;
      wr_bank_d          = ~wr_bank_q;
    end
    if (o_rd_acc && i_rd_last) begin
      state_d[rd_bank_q] = FREE;
      rd_bank_d          = ~rd_bank_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= '{default: FREE};
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: rtl/mem_streams_pp.sv
// Two-bank ping-pong block memory, CHANNELS lanes wide,
// one shared address stream per side.
module mem_streams_pp
  import mem_streams_pkg::*;
#(
  parameter int CHANNELS     = 16,
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 3
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_wr_wen,
  input  logic [ADDR_WIDTH-1:0]          i_wr_addr,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_wr_data,
  input  logic                           i_wr_last,
  output logic                           o_wr_ready,
  input  logic                           i_rd_ren,
  input  logic [ADDR_WIDTH-1:0]          i_rd_addr,
  input  logic                           i_rd_last,
  output logic                           o_rd_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH-1:0]          o_rd_addr,
  output logic                           o_tvalid,
  output logic                           o_rd_bank,
  output logic                           o_overflow
);

  localparam int P = READ_LATENCY + 1;

  logic wr_acc, rd_acc;
  logic wr_bank, rd_bank;

  pp_bank_ctrl u_ctrl (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr_wen   (i_wr_wen),
    .i_wr_last  (i_wr_last),
    .i_rd_ren   (i_rd_ren),
    .i_rd_last  (i_rd_last),
    .o_wr_ready (o_wr_ready),
    .o_rd_ready (o_rd_ready),
    .o_wr_acc   (wr_acc),
    .o_rd_acc   (rd_acc),
    .o_wr_bank  (wr_bank),
    .o_rd_bank  (rd_bank),
    .o_overflow (o_overflow)
  );

  logic                           wen_q;
  logic [ADDR_WIDTH:0]            waddr_q;
  logic [CHANNELS*DATA_WIDTH-1:0] wdata_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) wen_q <= 1'b0;
    else         wen_q <= wr_acc;
    waddr_q <= {wr_bank, i_wr_addr};
    wdata_q <= i_wr_data;
  end

  // Stage 0 registers the request; stages 1..P-1 track
  // the RAM's internal read pipeline.
  logic [P-1:0]        rvld_q;
  logic [ADDR_WIDTH:0] raddr_q [P];

  always_ff @(posedge i_clk) begin
    if (i_reset) rvld_q <= '0;
    else         rvld_q <= {rvld_q[P-2:0], rd_acc};
    raddr_q[0] <= {rd_bank, i_rd_addr};
    for (int i = 1; i < P; i++)
      raddr_q[i] <= raddr_q[i-1];
  end

  assign o_tvalid  = rvld_q[P-1];
  assign o_rd_addr = raddr_q[P-1][ADDR_WIDTH-1:0];
  assign o_rd_bank = raddr_q[P-1][ADDR_WIDTH];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    Simple_Dual_Port_BRAM_XPM_intel #(
      .ADDR_WIDTH   (ADDR_WIDTH + 1),
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
    ) u_ram (
      .clk   (i_clk),
      .wea   (wen_q),
      .addra (waddr_q),
      .dina  (wdata_q[g*DATA_WIDTH +: DATA_WIDTH]),
      .enb   (rvld_q[0]),
      .addrb (raddr_q[0]),
      .doutb (o_rd_data[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
